tdm_demux_1_4: RTL and testbench

TDM_DEMUX_1_4 -- requirements
Module: tdm_demux_1_4

---
 rtl/tdm_demux_1_4.sv | 155 +++++++++++++++
 tb/tb_tdm_demux_1_4.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1_4.sv
// tdm_demux_1_4: 1-to-4 time-division demultiplexer.
// A serial beat stream framed by a slot-0 sync marker is collected into three
// shadow registers and released onto four parallel lanes when slot 3 arrives.
// Optional feature: define TDM_DEMUX_ERR_CNT_EN to build a saturating
// sync-error counter on err_cnt; otherwise err_cnt is tied to zero.
module tdm_demux_1_4 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         sync,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic         frame_valid,
  output logic [1:0]   sel,
  output logic         locked,
  output logic         sync_err,
  output logic [7:0]   err_cnt
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [1:0]   slot_q, slot_d;
  logic [W-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [W-1:0] y0_q, y0_d, y1_q, y1_d, y2_q, y2_d, y3_q, y3_d;
  logic         fv_q, fv_d;
  logic         serr_q, serr_d;

  // Next-state: framing FSM, shadow capture and lane release on slot 3.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    y3_d    = y3_q;
    fv_d    = 1'b0;
    serr_d  = 1'b0;
    if (din_valid) begin
      if (state_q == IDLE) begin
        // Hunting for a frame start; non-sync beats are dropped.
        if (sync) begin
          sh0_d   = din;
          slot_d  = 2'd1;
          state_d = RUN;
        end
      end else if (slot_q == 2'd0) begin
        if (sync) begin
          sh0_d  = din;
          slot_d = 2'd1;
        end else begin
          // Missing frame start: lose lock.
          serr_d  = 1'b1;
          slot_d  = 2'd0;
          state_d = IDLE;
        end
      end else if (sync) begin
        // Early sync: abandon the partial frame and re-lock on this beat.
        serr_d = 1'b1;
        sh0_d  = din;
        slot_d = 2'd1;
      end else begin
        case (slot_q)
          2'd1: begin
            sh1_d  = din;
            slot_d = 2'd2;
          end
          2'd2: begin
            sh2_d  = din;
            slot_d = 2'd3;
          end
          default: begin
            y0_d   = sh0_q;
            y1_d   = sh1_q;
            y2_d   = sh2_q;
            y3_d   = din;
            fv_d   = 1'b1;
            slot_d = 2'd0;
          end
        endcase
      end
    end
  end

  // State, shadow and lane registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= 2'd0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      y3_q    <= '0;
      fv_q    <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      y3_q    <= y3_d;
      fv_q    <= fv_d;
      serr_q  <= serr_d;
    end
  end

`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Count every sync error, holding at the top of the range.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (serr_d) err_cnt_d = sat_inc(err_cnt_q);
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= 8'd0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'd0;
`endif

  assign y0          = y0_q;
  assign y1          = y1_q;
  assign y2          = y2_q;
  assign y3          = y3_q;
  assign frame_valid = fv_q;
  assign sel         = slot_q;
  assign locked      = (state_q == RUN);
  assign sync_err    = serr_q;

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Directed bench for tdm_demux_1_4 with a frame scoreboard.
module tb_tdm_demux_1_4;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         sync;
  logic [W-1:0] y0, y1, y2, y3;
  logic         frame_valid;
  logic [1:0]   sel;
  logic         locked;
  logic         sync_err;
  logic [7:0]   err_cnt;

  int vectors = 0;
  int fails   = 0;
  logic [4*W-1:0] exp_q[$];

  tdm_demux_1_4 #(.W(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .frame_valid(frame_valid),
    .sel(sel), .locked(locked), .sync_err(sync_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every frame_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", {y0, y1, y2, y3}, 32'hDEAD_BEEF);
      end else begin
        chk("frame_lanes", {y0, y1, y2, y3}, exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic [W-1:0] d, input logic v, input logic s);
    @(negedge clk);
    din = d; din_valid = v; sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; din_valid = 1'b0; sync = 1'b0; din = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_lanes"}, {y0, y1, y2, y3}, 32'h0);
    chk({tag, "_fv"}, frame_valid, 1'b0);
    chk({tag, "_serr"}, sync_err, 1'b0);
    chk({tag, "_locked"}, locked, 1'b0);
    chk({tag, "_sel"}, sel, 2'd0);
    chk({tag, "_errcnt"}, err_cnt, 8'd0);
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; sync = 1'b0;
    do_reset();
    chk_zero("reset");

    // Basic frame A1 B2 C3 D4.
    exp_q.push_back(32'hA1B2C3D4);
    step(8'hA1, 1, 1); chk("f1_locked", locked, 1'b1); chk("f1_sel1", sel, 2'd1);
    step(8'hB2, 1, 0); chk("f1_sel2", sel, 2'd2);
    step(8'hC3, 1, 0); chk("f1_sel3", sel, 2'd3); chk("f1_fv_early", frame_valid, 1'b0);
    step(8'hD4, 1, 0); chk("f1_fv", frame_valid, 1'b1); chk("f1_sel0", sel, 2'd0);
    chk("f1_locked_end", locked, 1'b1);
    step(8'h00, 0, 0); chk("f1_fv_pulse", frame_valid, 1'b0);
    chk("f1_hold", {y0, y1, y2, y3}, 32'hA1B2C3D4);

    // Back-to-back frames: pulses exactly 4 cycles apart.
    exp_q.push_back(32'h11121314);
    exp_q.push_back(32'h21222324);
    step(8'h11, 1, 1); step(8'h12, 1, 0); step(8'h13, 1, 0);
    step(8'h14, 1, 0); chk("b2b_fv1", frame_valid, 1'b1);
    step(8'h21, 1, 1); chk("b2b_gap1", frame_valid, 1'b0);
    step(8'h22, 1, 0); chk("b2b_gap2", frame_valid, 1'b0);
    step(8'h23, 1, 0); chk("b2b_gap3", frame_valid, 1'b0);
    step(8'h24, 1, 0); chk("b2b_fv2", frame_valid, 1'b1);

    // Valid gap of 3 cycles after slot-1 beat.
    exp_q.push_back(32'h01020304);
    step(8'h01, 1, 1); step(8'h02, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(8'hEE, 0, 1);
      chk("gap_sel", sel, 2'd2);
      chk("gap_fv", frame_valid, 1'b0);
    end
    step(8'h03, 1, 0); step(8'h04, 1, 0); chk("gap_fv_end", frame_valid, 1'b1);

    // Early sync on slot 2 re-locks.
    step(8'h31, 1, 1); step(8'h32, 1, 0);
    step(8'h55, 1, 1);
    chk("relock_serr", sync_err, 1'b1); chk("relock_sel", sel, 2'd1);
    chk("relock_fv", frame_valid, 1'b0); chk("relock_locked", locked, 1'b1);
    chk("relock_lanes", {y0, y1, y2, y3}, 32'h01020304);
    exp_q.push_back(32'h55667788);
    step(8'h66, 1, 0); chk("relock_serr_pulse", sync_err, 1'b0);
    step(8'h77, 1, 0);
    step(8'h88, 1, 0); chk("relock_fv_end", frame_valid, 1'b1);

    // Missing sync at slot 0 drops lock.
    do_reset();
    exp_q.push_back(32'h41424344);
    step(8'h41, 1, 1); step(8'h42, 1, 0); step(8'h43, 1, 0); step(8'h44, 1, 0);
    step(8'h99, 1, 0);
    chk("lost_serr", sync_err, 1'b1); chk("lost_locked", locked, 1'b0);
    chk("lost_sel", sel, 2'd0);
`ifdef TDM_DEMUX_ERR_CNT_EN
    chk("lost_errcnt1", err_cnt, 8'd1);
`else
    chk("lost_errcnt0", err_cnt, 8'd0);
`endif
    for (int i = 0; i < 5; i++) begin
      step(8'h50 + 8'(i), 1, 0);
      chk("idle_locked", locked, 1'b0);
      chk("idle_serr", sync_err, 1'b0);
    end
    chk("idle_lanes", {y0, y1, y2, y3}, 32'h41424344);
`ifdef TDM_DEMUX_ERR_CNT_EN
    for (int i = 0; i < 299; i++) begin
      step(8'h01, 1, 1);
      step(8'h02, 1, 0);
    end
    chk("errcnt_sat", err_cnt, 8'd255);
`endif

    // Reset mid-frame after slot-1 beat.
    do_reset();
    exp_q.push_back(32'h61626364);
    step(8'h61, 1, 1); step(8'h62, 1, 0); step(8'h63, 1, 0); step(8'h64, 1, 0);
    step(8'h71, 1, 1); step(8'h72, 1, 0);
    @(negedge clk);
    rst = 1'b1; din = 8'h73; din_valid = 1'b1; sync = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    step(8'h74, 1, 0); chk("midrst_fv", frame_valid, 1'b0); chk("midrst_locked", locked, 1'b0);
    step(8'h00, 0, 0); chk("midrst_fv2", frame_valid, 1'b0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
